regs: RTL

REGS -- requirements
Module: regs

---
 rtl/regs_pkg.sv | 13 +
 rtl/regs_rd_port.sv | 43 ++++
 rtl/regs.sv | 65 ++++++
 3 files changed

// File: rtl/regs_pkg.sv
// Shared constants for the integer register file.
//   ZERO_WORD   : all-zero 32-bit data word
//   ZERO_REG    : architectural address of x0
//   DEF_REG_NUM : default number of architectural registers
//   REG_ADDR_W  : register address width
package regs_pkg;

  localparam logic [31:0] ZERO_WORD   = 32'h0;
  localparam int          REG_ADDR_W  = 5;
  localparam logic [4:0]  ZERO_REG    = 5'd0;
  localparam int          DEF_REG_NUM = 32;

endpackage

// File: rtl/regs_rd_port.sv
// One combinational read port of the register file.
// Optional feature macro: REGS_WR_BYPASS_EN (write-to-read forwarding).
// Ports:
//   rst        : synchronous reset level; forces rdata to 0 while high
//   raddr      : read address
//   mem_data   : stored value at raddr, fetched by the parent
//   wen/waddr/wdata : write port of the same cycle (used for forwarding)
//   rdata      : read result
module regs_rd_port
  import regs_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] raddr,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  wen,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rdata
);

`ifndef REGS_WR_BYPASS_EN
  // Without forwarding the write port is not needed here.
  logic unused_wr;
  assign unused_wr = ^{wen, waddr, wdata};
`endif

  always_comb begin
    rdata = mem_data;
`ifdef REGS_WR_BYPASS_EN
    // A write landing this cycle is visible to a same-address read at once.
    if (wen && (waddr == raddr)) begin
      rdata = wdata;
    end
`endif
    // x0 has no storage, and reset masks both ports; these win over forwarding.
    if (rst || (raddr == ZERO_REG)) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/regs.sv
// Integer register file: x1..x(REG_NUM-1) storage, one write port,
// two independent combinational read ports. x0 reads as 0 and ignores writes.
// Optional feature macro: REGS_WR_BYPASS_EN (same-cycle write-to-read forwarding).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   reg_waddr_i/wdata_i/wen_i : write port from the ex stage
//   reg1_raddr_i/rdata_o : rs1 read port
//   reg2_raddr_i/rdata_o : rs2 read port
module regs
  import regs_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_NUM = DEF_REG_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic [XLEN-1:0]       reg_wdata_i,
  input  logic                  reg_wen_i,
  input  logic [REG_ADDR_W-1:0] reg1_raddr_i,
  output logic [XLEN-1:0]       reg1_rdata_o,
  input  logic [REG_ADDR_W-1:0] reg2_raddr_i,
  output logic [XLEN-1:0]       reg2_rdata_o
);

  // Index 0 deliberately absent: x0 is not storage.
  logic [XLEN-1:0] mem [1:REG_NUM-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_NUM; i++) begin
        mem[i] <= '0;
      end
    end else if (reg_wen_i && (reg_waddr_i != ZERO_REG)) begin
      mem[reg_waddr_i] <= reg_wdata_i;
    end
  end

  // Address 0 fetches nothing meaningful; the read port masks it to 0.
  logic [XLEN-1:0] mem_rd1;
  logic [XLEN-1:0] mem_rd2;
  assign mem_rd1 = mem[reg1_raddr_i];
  assign mem_rd2 = mem[reg2_raddr_i];

  regs_rd_port #(.XLEN(XLEN)) u_rd1 (
    .rst      (rst),
    .raddr    (reg1_raddr_i),
    .mem_data (mem_rd1),
    .wen      (reg_wen_i),
    .waddr    (reg_waddr_i),
    .wdata    (reg_wdata_i),
    .rdata    (reg1_rdata_o)
  );

  regs_rd_port #(.XLEN(XLEN)) u_rd2 (
    .rst      (rst),
    .raddr    (reg2_raddr_i),
    .mem_data (mem_rd2),
    .wen      (reg_wen_i),
    .waddr    (reg_waddr_i),
    .wdata    (reg_wdata_i),
    .rdata    (reg2_rdata_o)
  );

endmodule
